// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, halt/resume and
// EX operand forwarding select, with a saturating count of inserted bubbles.
module pipe_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] IF_ID_Read_Reg_Num,
  input  logic       IF_ID_Uses_Reg,
  input  logic       ID_EX_RegWrite,
  input  logic       ID_EX_MemRead,
  input  logic [2:0] ID_EX_Read_Reg_Num,
  input  logic [2:0] ID_EX_Write_Reg_Num,
  input  logic       EX_MEM_RegWrite,
  input  logic       MEM_WB_RegWrite,
  input  logic [2:0] EX_MEM_Write_Reg_Num,
  input  logic [2:0] MEM_WB_Write_Reg_Num,
  input  logic       Branch_Taken,
  input  logic       Halt_Req,
  input  logic       Resume,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic [1:0] Fwd_Sel,
  output logic [1:0] State,
  output logic [7:0] Bubble_Count
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [3:0] STALL_LOAD   = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);
  // A branch inside FLUSH must always buy at least one more flush cycle.
  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? FLUSH_LOAD : 4'd1;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic [7:0] bcnt_q;

  logic   hz;
  logic   halt_now;
  state_t exit_state;

  assign hz = ID_EX_MemRead & ID_EX_RegWrite & IF_ID_Uses_Reg &
              (ID_EX_Write_Reg_Num == IF_ID_Read_Reg_Num);
  assign halt_now   = pend_q | Halt_Req;
  assign exit_state = halt_now ? HALTED : RUN;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q | Halt_Req;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    unique case (state_q)
      RUN: begin
        if (Branch_Taken) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = exit_state;
          end
        end else if (hz) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = STALL_LOAD;
          end else begin
            state_d = exit_state;
          end
        end else if (halt_now) begin
          state_d = HALTED;
        end
      end
      STALL: begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = exit_state;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FLUSH: begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        if (Branch_Taken) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= 4'd1) begin
          state_d = exit_state;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALTED: begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        if (Resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Entering or sitting in HALTED consumes any pending request.
    if (state_d == HALTED) pend_d = 1'b0;
    if (!Reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_comb begin
    Fwd_Sel = 2'b00;
    if (EX_MEM_RegWrite && (EX_MEM_Write_Reg_Num == ID_EX_Read_Reg_Num)) begin
      Fwd_Sel = 2'b10;
    end else if (MEM_WB_RegWrite && (MEM_WB_Write_Reg_Num == ID_EX_Read_Reg_Num)) begin
      Fwd_Sel = 2'b01;
    end
    if (!Reset) Fwd_Sel = 2'b00;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      bcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (ID_EX_Bubble && (bcnt_q != 8'hFF)) bcnt_q <= bcnt_q + 8'd1;
    end
  end

  assign State        = state_q;
  assign Bubble_Count = bcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (short and long flush)
// share stimulus; expected values are hand-derived constants.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] IF_ID_Read_Reg_Num;
  logic       IF_ID_Uses_Reg;
  logic       ID_EX_RegWrite, ID_EX_MemRead;
  logic [2:0] ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num;
  logic       EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic [2:0] EX_MEM_Write_Reg_Num, MEM_WB_Write_Reg_Num;
  logic       Branch_Taken, Halt_Req, Resume;

  logic       a_pcw, a_ifw, a_fl, a_bub;
  logic [1:0] a_fwd, a_st;
  logic [7:0] a_cnt;
  logic       b_pcw, b_ifw, b_fl, b_bub;
  logic [1:0] b_fwd, b_st;
  logic [7:0] b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(1)) u_a (
    .Clk(Clk), .Reset(Reset),
    .IF_ID_Read_Reg_Num(IF_ID_Read_Reg_Num), .IF_ID_Uses_Reg(IF_ID_Uses_Reg),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Read_Reg_Num(ID_EX_Read_Reg_Num), .ID_EX_Write_Reg_Num(ID_EX_Write_Reg_Num),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .EX_MEM_Write_Reg_Num(EX_MEM_Write_Reg_Num), .MEM_WB_Write_Reg_Num(MEM_WB_Write_Reg_Num),
    .Branch_Taken(Branch_Taken), .Halt_Req(Halt_Req), .Resume(Resume),
    .PC_Write(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl), .ID_EX_Bubble(a_bub),
    .Fwd_Sel(a_fwd), .State(a_st), .Bubble_Count(a_cnt)
  );

  pipe_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(4)) u_b (
    .Clk(Clk), .Reset(Reset),
    .IF_ID_Read_Reg_Num(IF_ID_Read_Reg_Num), .IF_ID_Uses_Reg(IF_ID_Uses_Reg),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Read_Reg_Num(ID_EX_Read_Reg_Num), .ID_EX_Write_Reg_Num(ID_EX_Write_Reg_Num),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .EX_MEM_Write_Reg_Num(EX_MEM_Write_Reg_Num), .MEM_WB_Write_Reg_Num(MEM_WB_Write_Reg_Num),
    .Branch_Taken(Branch_Taken), .Halt_Req(Halt_Req), .Resume(Resume),
    .PC_Write(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl), .ID_EX_Bubble(b_bub),
    .Fwd_Sel(b_fwd), .State(b_st), .Bubble_Count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_in();
    IF_ID_Read_Reg_Num   = 3'd0;
    IF_ID_Uses_Reg       = 1'b0;
    ID_EX_RegWrite       = 1'b0;
    ID_EX_MemRead        = 1'b0;
    ID_EX_Read_Reg_Num   = 3'd0;
    ID_EX_Write_Reg_Num  = 3'd0;
    EX_MEM_RegWrite      = 1'b0;
    MEM_WB_RegWrite      = 1'b0;
    EX_MEM_Write_Reg_Num = 3'd0;
    MEM_WB_Write_Reg_Num = 3'd0;
    Branch_Taken         = 1'b0;
    Halt_Req             = 1'b0;
    Resume               = 1'b0;
  endtask

  task automatic load_use();
    ID_EX_MemRead       = 1'b1;
    ID_EX_RegWrite      = 1'b1;
    ID_EX_Write_Reg_Num = 3'd3;
    IF_ID_Read_Reg_Num  = 3'd3;
    IF_ID_Uses_Reg      = 1'b1;
  endtask

  initial begin
    clr_in();
    Reset = 1'b0;
    // reset outputs, with a forwarding match present that must be masked
    EX_MEM_RegWrite = 1'b1;
    cyc();
    #1;
    check("rst_state", 32'(a_st), 0);
    check("rst_pcw", 32'(a_pcw), 0);
    check("rst_ifw", 32'(a_ifw), 0);
    check("rst_flush", 32'(a_fl), 1);
    check("rst_bubble", 32'(a_bub), 1);
    check("rst_fwd", 32'(a_fwd), 0);
    cyc();
    check("rst_cnt_hold", 32'(a_cnt), 0);

    Reset = 1'b1;
    clr_in();
    #1;
    check("run_pcw", 32'(a_pcw), 1);
    check("run_flush", 32'(a_fl), 0);
    check("run_bubble", 32'(a_bub), 0);

    // load-use, STALL_CYCLES=2 on A, 3 on B
    cyc();
    load_use();
    #1;
    check("lu_pcw0", 32'(a_pcw), 0);
    check("lu_bub0", 32'(a_bub), 1);
    check("lu_st0", 32'(a_st), 0);
    cyc();
    clr_in();
    #1;
    check("lu_st1", 32'(a_st), 1);
    check("lu_pcw1", 32'(a_pcw), 0);
    cyc();
    check("lu_st2", 32'(a_st), 0);
    check("lu_pcw2", 32'(a_pcw), 1);
    check("lu_cnt", 32'(a_cnt), 2);
    check("lu_b_st2", 32'(b_st), 1);
    cyc();
    check("lu_b_st3", 32'(b_st), 0);
    check("lu_b_cnt", 32'(b_cnt), 3);

    // branch with hazard also present: branch wins
    Branch_Taken = 1'b1;
    load_use();
    #1;
    check("br_flush", 32'(a_fl), 1);
    check("br_pcw", 32'(a_pcw), 1);
    check("br_ifw", 32'(a_ifw), 1);
    check("br_bub", 32'(a_bub), 1);
    check("br_b_pcw", 32'(b_pcw), 1);
    cyc();
    clr_in();
    #1;
    check("br_st", 32'(a_st), 0);
    check("br_flush_off", 32'(a_fl), 0);
    check("br_cnt", 32'(a_cnt), 3);
    check("br_b_st", 32'(b_st), 2);
    check("br_b_flush", 32'(b_fl), 1);

    // reset while B sits in FLUSH with counter 3
    Reset = 1'b0;
    #1;
    check("rf_b_flush", 32'(b_fl), 1);
    check("rf_b_pcw", 32'(b_pcw), 0);
    cyc();
    Reset = 1'b1;
    #1;
    check("rf_b_st", 32'(b_st), 0);
    check("rf_b_flush_off", 32'(b_fl), 0);
    check("rf_b_cnt", 32'(b_cnt), 0);
    check("rf_a_cnt", 32'(a_cnt), 0);

    // halt requested during a stall
    cyc();
    load_use();
    #1;
    check("hs_pcw0", 32'(a_pcw), 0);
    cyc();
    clr_in();
    Halt_Req = 1'b1;
    #1;
    check("hs_st1", 32'(a_st), 1);
    cyc();
    Halt_Req = 1'b0;
    #1;
    check("hs_st_halt", 32'(a_st), 3);
    check("hs_pcw_halt", 32'(a_pcw), 0);
    check("hs_bub_halt", 32'(a_bub), 1);
    check("hs_b_st", 32'(b_st), 1);
    cyc();
    check("hs_b_halt", 32'(b_st), 3);
    Resume = 1'b1;
    #1;
    check("hs_resume_st", 32'(a_st), 3);
    cyc();
    Resume = 1'b0;
    #1;
    check("hs_run_st", 32'(a_st), 0);
    check("hs_run_pcw", 32'(a_pcw), 1);
    check("hs_b_run", 32'(b_st), 0);
    cyc();
    check("hs_no_rehalt", 32'(a_st), 0);

    // halt from idle RUN, then saturate bubble counter
    Halt_Req = 1'b1;
    #1;
    check("hr_pcw", 32'(a_pcw), 1);
    check("hr_bub", 32'(a_bub), 0);
    cyc();
    Halt_Req = 1'b0;
    #1;
    check("hr_st", 32'(a_st), 3);
    repeat (300) cyc();
    check("sat_a_cnt", 32'(a_cnt), 255);
    check("sat_b_cnt", 32'(b_cnt), 255);
    check("sat_st", 32'(a_st), 3);
    Reset = 1'b0;
    cyc();
    Reset = 1'b1;
    #1;
    check("sat_rst_cnt", 32'(a_cnt), 0);
    check("sat_rst_st", 32'(a_st), 0);
    check("sat_rst_b_st", 32'(b_st), 0);

    // forwarding select
    EX_MEM_RegWrite      = 1'b1;
    EX_MEM_Write_Reg_Num = 3'd5;
    MEM_WB_RegWrite      = 1'b1;
    MEM_WB_Write_Reg_Num = 3'd5;
    ID_EX_Read_Reg_Num   = 3'd5;
    #1;
    check("fwd_both", 32'(a_fwd), 2);
    EX_MEM_RegWrite = 1'b0;
    #1;
    check("fwd_memwb", 32'(a_fwd), 1);
    EX_MEM_RegWrite      = 1'b1;
    EX_MEM_Write_Reg_Num = 3'd6;
    #1;
    check("fwd_exmem_miss", 32'(a_fwd), 1);
    MEM_WB_RegWrite = 1'b0;
    #1;
    check("fwd_none", 32'(a_fwd), 0);
    clr_in();
    // Uses_Reg low: no hazard
    load_use();
    IF_ID_Uses_Reg = 1'b0;
    #1;
    check("nohz_pcw", 32'(a_pcw), 1);
    clr_in();

    // branch inside FLUSH reloads B's counter
    cyc();
    Branch_Taken = 1'b1;
    cyc();
    #1;
    check("rl_b_flush", 32'(b_fl), 1);
    check("rl_b_pcw", 32'(b_pcw), 1);
    cyc();
    Branch_Taken = 1'b0;
    cyc();
    cyc();
    check("rl_b_st_mid", 32'(b_st), 2);
    check("rl_a_st", 32'(a_st), 0);
    cyc();
    check("rl_b_st_end", 32'(b_st), 0);
    check("rl_b_flush_off", 32'(b_fl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter STALL_CYCLES, default 1, bubble cycles inserted per load-use hazard (legal range 1..15).
REQ-002 Parameter FLUSH_CYCLES, default 1, bubble cycles inserted per taken branch (legal range 1..15).
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-low; reset takes effect at a posedge Clk with Reset==0.
REQ-005 IF_ID_Read_Reg_Num  in  3  source register of the instruction in ID.
REQ-006 IF_ID_Uses_Reg  in  1  the instruction in ID reads IF_ID_Read_Reg_Num.
REQ-007 ID_EX_RegWrite, ID_EX_MemRead  in  1 each  control bits of the instruction in EX.
REQ-008 ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num  in  3 each  source and destination registers in EX.
REQ-009 EX_MEM_RegWrite, MEM_WB_RegWrite  in  1 each; EX_MEM_Write_Reg_Num, MEM_WB_Write_Reg_Num  in  3 each.
REQ-010 Branch_Taken  in  1  branch resolved taken in EX this cycle.
REQ-011 Halt_Req  in  1  single-cycle halt request pulse; Resume  in  1  leave halt.
REQ-012 PC_Write, IF_ID_Write  out  1 each  enables for PC and IF/ID registers.
REQ-013 IF_ID_Flush, ID_EX_Bubble  out  1 each  clear IF/ID; force ID/EX RegWrite and ALUSrc to 0.
REQ-014 Fwd_Sel  out  2  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-015 State  out  2  RUN=00, STALL=01, FLUSH=10, HALTED=11.
REQ-016 Bubble_Count  out  8  saturating count of cycles with ID_EX_Bubble==1.

Function
REQ-017 Hazard: hz = ID_EX_MemRead & ID_EX_RegWrite & IF_ID_Uses_Reg & (ID_EX_Write_Reg_Num==IF_ID_Read_Reg_Num).
REQ-018 RUN with no event: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-019 RUN priority is Branch_Taken over hz; Halt_Req is latched independently into Halt_Pending.
REQ-020 RUN with Branch_Taken: same cycle IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, IF_ID_Write=1; next state FLUSH with counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else next state per REQ-024.
REQ-021 RUN with hz and no branch: same cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next state STALL with counter=STALL_CYCLES-1 if STALL_CYCLES>1, else next state per REQ-024.
REQ-022 STALL: outputs as REQ-021; counter decrements each cycle; exit at counter==1; Branch_Taken ignored.
REQ-023 FLUSH: outputs as REQ-020; counter decrements; exit at counter==1; Branch_Taken in FLUSH reloads counter=FLUSH_CYCLES-1 (with FLUSH_CYCLES==1, stay one more cycle).
REQ-024 Exit from RUN events, STALL or FLUSH goes to HALTED if Halt_Pending (or Halt_Req this cycle), else RUN.
REQ-025 RUN with no event and Halt_Pending or Halt_Req: normal outputs that cycle; next state HALTED.
REQ-026 HALTED: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0; Halt_Pending cleared on entry; Resume -> RUN next cycle; Halt_Req ignored.
REQ-027 Fwd_Sel combinational in all states: 10 if EX_MEM_RegWrite & EX_MEM_Write_Reg_Num==ID_EX_Read_Reg_Num; else 01 if MEM_WB match; else 00. EX/MEM wins on a double match.
REQ-028 Bubble_Count increments when ID_EX_Bubble==1 at posedge Clk, saturates at 255, never wraps.

Reset
REQ-029 Reset==0 at posedge: State=RUN, counter=0, Halt_Pending=0, Bubble_Count=0.
REQ-030 While Reset==0: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, Fwd_Sel=00; Bubble_Count does not increment.
REQ-031 Reset mid-STALL, mid-FLUSH or in HALTED aborts to RUN; a pending halt is discarded.

Verification
REQ-032 Load-use: MemRead=1, RegWrite=1, EX dest=3, ID src=3, Uses_Reg=1, STALL_CYCLES=2 -> PC_Write=0 for 2 cycles, State 00->01->00, Bubble_Count=2.
REQ-033 Branch_Taken with hz also true, FLUSH_CYCLES=1 -> IF_ID_Flush=1 one cycle, PC_Write=1, State stays 00.
REQ-034 Halt_Req during STALL -> STALL completes, State=11, PC_Write=0; Resume pulse -> State=00 next cycle.
REQ-035 EX_MEM and MEM_WB both write reg 5, EX src=5 -> Fwd_Sel=10; EX_MEM_RegWrite dropped -> 01.
REQ-036 Hold in HALTED for 300 cycles -> Bubble_Count=255; Reset=0 one cycle -> count 0, State=00.
REQ-037 Reset=0 asserted in FLUSH with counter=3 -> State=00 next cycle, IF_ID_Flush=1 only during the reset cycle.
